// File: rtl/coin_pkg.sv
// coin_pkg: shared coin codes, default parameters and code decode helper
package coin_pkg;
  typedef enum logic [1:0] {NONE = 2'd0, ONE = 2'd1, TWO = 2'd2, FIVE = 2'd3} coin_t;
  localparam int DEBOUNCE_DEF = 4;
  localparam int DEPTH_DEF = 4;
  function automatic logic [2:0] coin_onehot(input coin_t c);
    return {c == FIVE, c == TWO, c == ONE};
  endfunction
endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: synchronizes and debounces one chute sensor, flags accepted rising edges
module coin_debounce import coin_pkg::*; #(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);
  logic s1, s2, deb;
  logic [3:0] cnt;
  logic flip;
  assign flip = (s2 != deb) && cnt == 4'(DEBOUNCE - 1);
  // sync chain, mismatch counter that restarts on agreement, registered rise event
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      deb <= 1'b0;
      cnt <= '0;
      rise <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      cnt <= (s2 == deb || flip) ? '0 : cnt + 4'd1;
      deb <= flip ? s2 : deb;
      rise <= flip & s2;
    end
  end
endmodule

// File: rtl/coin_front.sv
// coin_front: conditions three coin chutes into an ordered queue replayed as paced pulses
module coin_front import coin_pkg::*; #(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic coin1_raw,
  input  logic coin2_raw,
  input  logic coin5_raw,
  input  logic pour,
  output logic one,
  output logic two,
  output logic five,
  output logic reject,
  output logic ovf,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [2:0] ev;
  coin_t mem [DEPTH];
  logic [AW-1:0] wr, rd, w1, w2;
  logic [LW-1:0] free, npush;
  logic a1, a2, a5, drop, pop;
  coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_c1 (.clk(clk), .rst(rst), .raw(coin1_raw), .rise(ev[0]));
  coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_c2 (.clk(clk), .rst(rst), .raw(coin2_raw), .rise(ev[1]));
  coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_c5 (.clk(clk), .rst(rst), .raw(coin5_raw), .rise(ev[2]));
  // accept events in one/two/five order against free slots; pop only when the line is quiet
  always_comb begin
    free = LW'(DEPTH) - level;
    a1 = ev[0] && free != '0;
    a2 = ev[1] && free > LW'(a1);
    a5 = ev[2] && free > LW'(a1) + LW'(a2);
    npush = LW'(a1) + LW'(a2) + LW'(a5);
    drop = |(ev & ~{a5, a2, a1});
    pop = level != '0 && !pour && !(one | two | five);
    w1 = wr + AW'(a1);
    w2 = w1 + AW'(a2);
  end
  // queue storage, up to three consecutive slots written per edge
  always_ff @(posedge clk) begin
    if (a1) mem[wr] <= ONE;
    if (a2) mem[w1] <= TWO;
    if (a5) mem[w2] <= FIVE;
  end
  // pointers, occupancy and registered pulse/reject outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      level <= '0;
      {five, two, one} <= 3'b0;
      reject <= 1'b0;
      ovf <= 1'b0;
    end else begin
      wr <= w2 + AW'(a5);
      rd <= rd + AW'(pop);
      level <= level + npush - LW'(pop);
      {five, two, one} <= pop ? coin_onehot(mem[rd]) : 3'b0;
      reject <= drop;
      ovf <= ovf | drop;
    end
  end
endmodule

// File: tb/tb_coin_front.sv
// tb_coin_front: directed scenario checks of the coin front end
module tb_coin_front;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic coin1_raw = 1'b0, coin2_raw = 1'b0, coin5_raw = 1'b0, pour = 1'b0;
  logic one, two, five, reject, ovf;
  logic [2:0] level;
  int checks = 0;
  int errors = 0;
  coin_front dut (
    .clk(clk), .rst(rst), .coin1_raw(coin1_raw), .coin2_raw(coin2_raw), .coin5_raw(coin5_raw),
    .pour(pour), .one(one), .two(two), .five(five), .reject(reject), .ovf(ovf), .level(level)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    coin1_raw = 0; coin2_raw = 0; coin5_raw = 0; pour = 0;
    repeat (n) step();
  endtask
  task automatic test_reset();
    rst = 1;
    step(); step();
    checks++;
    if ({one, two, five, reject, ovf} !== 5'b0) begin errors++; $display("FAIL reset_outs got %b want 00000", {one, two, five, reject, ovf}); end
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    rst = 0;
  endtask
  task automatic test_clean();
    int n = 0, at = -1, stray = 0;
    coin2_raw = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (two) begin n++; at = i; end
      if (one | five) stray++;
      if (i == 6) begin
        checks++;
        if (level !== 3'd1) begin errors++; $display("FAIL clean_level_push got %0d want 1", level); end
      end
      if (i == 9) coin2_raw = 0;
    end
    checks++;
    if (n !== 1 || at !== 7) begin errors++; $display("FAIL clean_two got count %0d at %0d want 1 at 7", n, at); end
    checks++;
    if (stray !== 0 || level !== 3'd0) begin errors++; $display("FAIL clean_idle got stray %0d level %0d want 0 0", stray, level); end
  endtask
  task automatic test_bounce();
    int n = 0, at = -1, g = 0;
    for (int i = 0; i < 30; i++) begin
      coin1_raw = (i < 6) ? (i % 2 == 0) : (i < 16);
      step();
      if (one) begin n++; at = i; end
    end
    checks++;
    if (n !== 1 || at !== 13) begin errors++; $display("FAIL bounce_one got count %0d at %0d want 1 at 13", n, at); end
    for (int i = 0; i < 20; i++) begin
      coin5_raw = (i < 3);
      step();
      if (one | two | five) g++;
    end
    checks++;
    if (g !== 0) begin errors++; $display("FAIL glitch got %0d pulses want 0", g); end
  endtask
  task automatic test_simul();
    int a1 = -1, a2 = -1, a5 = -1, n = 0, mx = 0;
    for (int i = 0; i < 25; i++) begin
      coin1_raw = (i < 10); coin2_raw = (i < 10); coin5_raw = (i < 10);
      step();
      if (one) begin a1 = i; n++; end
      if (two) begin a2 = i; n++; end
      if (five) begin a5 = i; n++; end
      if (int'(level) > mx) mx = int'(level);
    end
    checks++;
    if (a1 !== 7 || a2 !== 9 || a5 !== 11 || n !== 3) begin errors++; $display("FAIL simul_order got %0d %0d %0d n %0d want 7 9 11 n 3", a1, a2, a5, n); end
    checks++;
    if (mx !== 3) begin errors++; $display("FAIL simul_peak got %0d want 3", mx); end
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL simul_drain got %0d want 0", level); end
  endtask
  task automatic test_pour();
    int a2 = -1, a5 = -1, ov = 0;
    for (int i = 0; i < 25; i++) begin
      coin2_raw = (i < 10); coin5_raw = (i < 10);
      step();
      if (two) a2 = i;
      if (five) a5 = i;
      if (pour && (one | two | five)) ov++;
      if (i == 8) pour = 1;
      if (i == 13) pour = 0;
    end
    checks++;
    if (a2 !== 7 || a5 !== 14) begin errors++; $display("FAIL pour_timing got two %0d five %0d want 7 14", a2, a5); end
    checks++;
    if (ov !== 0) begin errors++; $display("FAIL pour_overlap got %0d want 0", ov); end
  endtask
  task automatic test_overflow();
    int seq[$];
    int ts[$];
    int nr = 0, ar = -1;
    pour = 1;
    for (int i = 0; i < 60; i++) begin
      coin1_raw = (i < 10) || (i >= 20 && i < 30);
      coin2_raw = coin1_raw;
      coin5_raw = (i < 10);
      step();
      if (reject) begin nr++; ar = i; end
      if (one | two | five) begin seq.push_back(one ? 1 : two ? 2 : 3); ts.push_back(i); end
      if (i == 30) begin
        checks++;
        if (level !== 3'd4 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_full got level %0d ovf %b want 4 1", level, ovf); end
      end
      if (i == 40) pour = 0;
    end
    checks++;
    if (nr !== 1 || ar !== 26) begin errors++; $display("FAIL ovf_reject got count %0d at %0d want 1 at 26", nr, ar); end
    checks++;
    if (seq.size() !== 4) begin errors++; $display("FAIL ovf_count got %0d want 4", seq.size()); end
    else begin
      checks++;
      if (seq[0] !== 1 || seq[1] !== 2 || seq[2] !== 3 || seq[3] !== 1) begin errors++; $display("FAIL ovf_order got %0d%0d%0d%0d want 1231", seq[0], seq[1], seq[2], seq[3]); end
      checks++;
      if (ts[0] !== 41 || ts[1] !== 43 || ts[2] !== 45 || ts[3] !== 47) begin errors++; $display("FAIL ovf_times got %0d %0d %0d %0d want 41 43 45 47", ts[0], ts[1], ts[2], ts[3]); end
    end
    checks++;
    if (level !== 3'd0 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_end got level %0d ovf %b want 0 1", level, ovf); end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    pour = 1;
    for (int i = 0; i < 12; i++) begin
      coin1_raw = (i < 10); coin2_raw = (i < 10); coin5_raw = (i < 10);
      step();
    end
    checks++;
    if (level !== 3'd3) begin errors++; $display("FAIL mid_level got %0d want 3", level); end
    rst = 1;
    step();
    rst = 0;
    pour = 0;
    checks++;
    if ({one, two, five, reject, ovf} !== 5'b0 || level !== 3'd0) begin errors++; $display("FAIL mid_reset got %b level %0d want 00000 level 0", {one, two, five, reject, ovf}, level); end
    for (int i = 0; i < 20; i++) begin
      step();
      if (one | two | five | reject) n++;
    end
    checks++;
    if (n !== 0 || level !== 3'd0 || ovf !== 1'b0) begin errors++; $display("FAIL mid_after got pulses %0d level %0d ovf %b want 0 0 0", n, level, ovf); end
  endtask
  initial begin
    test_reset();
    test_clean();
    idle(10);
    test_bounce();
    idle(10);
    test_simul();
    idle(10);
    test_pour();
    idle(10);
    test_overflow();
    idle(10);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/coin_front.md
# coin_front

Front-end coin conditioner sitting directly upstream of the vending controller FSM. It synchronizes and debounces the three raw coin-chute sensors, turns each accepted coin into an ordered queue entry, and replays the queue as one-hot, single-cycle `one`/`two`/`five` pulses. Pulses are paced so that none lands in a cycle where the controller would discard it. The controller drops any coin pulse seen while it is in a pour state and acts on only one coin per cycle.

## Interface
Parameters:
- `DEBOUNCE`, 4: consecutive stable cycles required before a synchronized sensor level is accepted (legal 1..15).
- `DEPTH`, 4: coin queue depth in entries (power of two, ≥ 4).

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `coin1_raw` input 1: asynchronous, bouncy 1-unit chute sensor, high while a coin passes.
- `coin2_raw` input 1: same, 2-unit chute.
- `coin5_raw` input 1: same, 5-unit chute.
- `pour` input 1: controller pour indication; coin pulses are blocked while high.
- `one` output 1: registered 1-cycle pulse, one 1-unit coin.
- `two` output 1: registered 1-cycle pulse, one 2-unit coin.
- `five` output 1: registered 1-cycle pulse, one 5-unit coin.
- `reject` output 1: registered 1-cycle pulse, at least one coin dropped this cycle (queue full); drives the chute return gate.
- `ovf` output 1: sticky; set with any `reject`, cleared only by `rst`.
- `level` output $clog2(DEPTH)+1: current queue occupancy.

## Operation
- Per channel: 2-flop synchronizer, then debounce. The debounced level `deb` flips when the synchronized value has differed from `deb` for `DEBOUNCE` consecutive cycles. Any agreeing cycle clears the mismatch counter (4-bit, no wrap).
- Coin event: registered detection of the `deb` 0→1 transition. A falling transition produces no event.
- Queue: FIFO of 2-bit codes (ONE=1, TWO=2, FIVE=3) that preserves arrival order.
- When events from several channels occur in the same cycle, all are pushed in order one, two, five. Up to 3 writes per edge.
- If free slots are fewer than the number of simultaneous events, the highest-order events that fit are kept and the rest are dropped. Any drop asserts `reject` for 1 cycle and sets `ovf`.
- Pop/emit: at an edge, the head entry is popped into the output register only when all three hold:
  - the queue is non-empty before the edge;
  - `pour` is 0;
  - no pulse is being driven in the current cycle (gap rule).
- Otherwise the outputs register 0.
- Push and pop at the same edge are legal. A pop sees only entries present before that edge. `level` = old level + pushes − pop.
- Invariants: `one`, `two` and `five` are mutually exclusive. At least one idle cycle separates consecutive pulses.

## Timing
- Reset values:
  - outputs: `one`=`two`=`five`=`reject`=`ovf`=0, `level`=0;
  - internal: synchronizers 0, `deb` 0, counters 0, queue empty.
- Latency, idle empty queue, `pour`=0: raw high first sampled at edge k, pulse high during the cycle after edge k+3+`DEBOUNCE` (edge k+7 at default).
  - sync: edges k, k+1;
  - `deb` set: edge k+1+`DEBOUNCE`;
  - push: edge k+2+`DEBOUNCE`;
  - emit: next edge.
- Pacing: if a pulse is driven in cycle c, the controller's pour state is visible in cycle c+1. The gap rule covers c+1 and `pour` covers the pour cycle. The next pulse comes no earlier than c+2, or c+3 after a pour.
- Glitches shorter than `DEBOUNCE` synchronized cycles produce no event.
- Reset mid-operation: the queue is flushed, and in-flight and queued coins are lost without `reject`.

## Structure
- Shared package `coin_pkg`:
  - coin code typedef (NONE/ONE/TWO/FIVE, 2 bits);
  - `DEBOUNCE` and `DEPTH` defaults;
  - a code-to-one-hot decode function reused by the controller bench.
- One sub-module, `coin_debounce`: synchronizer, debounce counter and rise-event register. It is instantiated three times.
- Queue, multi-push logic and emit pacing stay in `coin_front`.

## Test plan
- Clean single coin: `coin2_raw` high 10 cycles from edge 0 → `two` high exactly once, in the cycle after edge 7; `level` returns to 0.
- Bounce: `coin1_raw` toggling every cycle for 6 cycles, then steady high 10 cycles → exactly one `one` pulse; glitch-only runs of 3 cycles yield none.
- Simultaneous events: all three raw inputs rise together → pulses `one`, `two`, `five` in that order with 1-cycle gaps; `level` peaks at 3.
- Pour blocking: queue holds TWO,FIVE and `pour` is held high 5 cycles after the first pulse → `five` withheld until the cycle after `pour` falls; no pulse overlaps `pour`.
- Overflow: `DEPTH`=4, `pour` held high, 5 coins injected → `level`=4, one `reject` pulse, `ovf`=1; after `pour` drops, exactly 4 pulses in arrival order.
- Reset mid-queue: `rst` asserted for one edge with `level`=3 → all outputs 0 the following cycle, no further pulses, and `ovf` cleared.
